accum_proc_gen2: RTL
====================

# accum_proc_gen2

Parametrised second-generation accumulator processor: one DW-bit accumulator, an NREG-entry register bank, and a 4-bit opcode space. It adds logic and shift operations, a zero flag, and illegal-opcode detection. Instructions enter through a valid/ready handshake, and results leave through a valid/ready output port with backpressure. It sits between the instruction source (switch/test sequencer) and the result display/consumer.

## Interface
Parameters:
- DW, 8, datapath and immediate width; legal range ≥4.
- NREG, 8, register-bank depth; power of two, 2..2^DW.
- Derived: RIW = clog2(NREG); SHW = clog2(DW); IW = 4 + DW.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr  in  IW  instruction. [IW-1:DW] opcode, [DW-1:0] immediate, register index = instr[DW-1 -: RIW].
- instr_valid  in  1  instr presented.
- instr_ready  out  1  block can accept an instruction.
- output_result  out  DW  value emitted by OUT.
- out_valid  out  1  output_result valid.
- out_ready  in  1  consumer accepts output_result.
- accumulator  out  DW  current accumulator.
- signflag  out  1  borrow from last subtract.
- overflowflag  out  1  carry-out from last add.
- zeroflag  out  1  accumulator == 0 after last accumulator write.
- illegal_op  out  1  sticky; set by an undefined opcode.
- busy  out  1  state != IDLE.

## Operation
Opcodes, with A = accumulator, I = immediate, R = reg[index]:
- 0 LDI: A=I. 1 LDR: A=R. 2 STR: R=A.
- 3 ADDI: A=A+I. 4 SUBI: A=A-I. 5 ADDR: A=A+R. 6 SUBR: A=A-R.
- 7 OUT: emit A. 8 AND: A=A&R. 9 OR: A=A|R. 10 XOR: A=A^R.
- 11 SHL: A=A<<I[SHW-1:0]. 12 SHR: A=A>>I[SHW-1:0], logical. 13 NOP.
- 14, 15: illegal.

Flag rules:
- Arithmetic is DW+1 wide.
- Add: overflowflag = bit DW of the sum; signflag cleared.
- Sub: signflag = (A < operand), unsigned; overflowflag cleared; A wraps modulo 2^DW.
- Logic and shift ops clear signflag and overflowflag.
- LDI, LDR, STR, OUT and NOP leave signflag and overflowflag unchanged.
- zeroflag updates on every op that writes A; other ops leave it unchanged.
- Illegal opcode: sets illegal_op and otherwise behaves as NOP. illegal_op clears only on reset.
- STR to any index writes only that register. A STR immediately followed by LDR/ADDR of the same index sees the new value.

## Timing
FSM states: IDLE, EXEC, OUT_WAIT.
- IDLE: instr_ready=1. On instr_valid & instr_ready, instr is captured into instr_q and the FSM goes to EXEC.
- EXEC: instr_ready=0. At the next edge A, registers, flags and illegal_op commit.
  - Non-OUT ops return to IDLE.
  - OUT loads output_result<=A, sets out_valid<=1, and goes to OUT_WAIT.
- OUT_WAIT: instr_ready=0; output_result and out_valid held stable.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
  - out_ready may be high on the first OUT_WAIT cycle; then out_valid lasts exactly one cycle.

Throughput and latency:
- Peak throughput is one instruction per 2 cycles. OUT takes at least 3 cycles.
- Effects are visible on outputs 2 edges after the accept edge.
- instr_valid while instr_ready=0 is ignored. The source must hold instr stable until it is accepted.

Reset (async assert, sync release):
- All registers, A, output_result and every flag go to 0; out_valid=0; FSM goes to IDLE.
- instr_ready=0 while reset_n=0.
- Reset during EXEC or OUT_WAIT aborts the instruction with no commit; a pending output is dropped.

## Structure
- Package accum_proc_gen2_pkg holds:
  - opcode enum (4 bits: LDI..NOP, plus the illegal range);
  - FSM state enum;
  - field-extraction functions parametrised on DW/NREG.
- One sub-module, accum_proc_alu: combinational. Inputs: opcode, A, operand, shift amount. Outputs: result, carry, borrow, and write-enables for A and the flags.
- Register bank and FSM stay in the top level.

## Test plan
(DW=8, NREG=8)
- Reset then LDI 0x04, then STR with I=0x3F (index 1) -> accumulator=0x04, reg1=0x04, zeroflag=0, flags 0.
- LDI 0xF0, ADDI 0x20 -> accumulator=0x10, overflowflag=1, signflag=0. Then SUBI 0x11 -> 0xFF, signflag=1, overflowflag=0.
- LDI 0x04, STR index 2, LDI 0x03, SUBR index 2 -> 0xFF, signflag=1. Then XOR index 2 -> 0xFB. Then SHR I=0x03 -> 0x1F.
- LDI 0x5A, OUT with out_ready low for 3 cycles -> out_valid=1 and output_result=0x5A held, instr_ready=0 throughout. out_ready high -> out_valid drops next edge, instr_ready=1.
- Opcode 14 -> illegal_op=1, accumulator unchanged. Then reset_n pulsed low during an EXEC of LDI 0x33 -> all outputs 0, accumulator≠0x33, illegal_op=0.

Source files
------------

// File: rtl/accum_proc_gen2_pkg.sv
// rtl/accum_proc_gen2_pkg.sv - shared types and instruction field helpers for accum_proc_gen2
package accum_proc_gen2_pkg;

  typedef enum logic [3:0] {
    OP_LDI   = 4'd0,
    OP_LDR   = 4'd1,
    OP_STR   = 4'd2,
    OP_ADDI  = 4'd3,
    OP_SUBI  = 4'd4,
    OP_ADDR  = 4'd5,
    OP_SUBR  = 4'd6,
    OP_OUT   = 4'd7,
    OP_AND   = 4'd8,
    OP_OR    = 4'd9,
    OP_XOR   = 4'd10,
    OP_SHL   = 4'd11,
    OP_SHR   = 4'd12,
    OP_NOP   = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_EXEC     = 2'd1,
    ST_OUT_WAIT = 2'd2
  } state_e;

  // Instructions are passed zero-extended to 64 bits so one helper serves any DW.
  function automatic logic [3:0] instr_opcode(input logic [63:0] instr, input int dw);
    return instr[dw +: 4];
  endfunction

  function automatic logic [63:0] instr_imm(input logic [63:0] instr, input int dw);
    return instr & ((64'd1 << dw) - 64'd1);
  endfunction

  // Register index lives in the top RIW bits of the immediate.
  function automatic logic [63:0] instr_ridx(input logic [63:0] instr, input int dw, input int riw);
    return (instr >> (dw - riw)) & ((64'd1 << riw) - 64'd1);
  endfunction

endpackage

// File: rtl/accum_proc_alu.sv
// rtl/accum_proc_alu.sv - combinational ALU with accumulator and flag write-enables
module accum_proc_alu
  import accum_proc_gen2_pkg::*;
#(
  parameter int DW  = 8,
  parameter int SHW = 3
) (
  input  logic [3:0]    opcode,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] operand,
  input  logic [SHW-1:0] shamt,
  output logic [DW-1:0] result,
  output logic          carry,
  output logic          borrow,
  output logic          a_we,
  output logic          flag_we
);

  logic [DW:0] sum;
  logic [DW:0] diff;

  assign sum  = {1'b0, a} + {1'b0, operand};
  assign diff = {1'b0, a} - {1'b0, operand};

  // Decode the opcode into a result and which state it is allowed to touch.
  always_comb begin
    result  = a;
    carry   = 1'b0;
    borrow  = 1'b0;
    a_we    = 1'b0;
    flag_we = 1'b0;
    case (opcode_e'(opcode))
      OP_LDI, OP_LDR: begin
        result = operand;
        a_we   = 1'b1;
      end
      OP_ADDI, OP_ADDR: begin
        result  = sum[DW-1:0];
        carry   = sum[DW];
        a_we    = 1'b1;
        flag_we = 1'b1;
      end
      OP_SUBI, OP_SUBR: begin
        // The extra bit of the wide difference is the unsigned borrow.
        result  = diff[DW-1:0];
        borrow  = diff[DW];
        a_we    = 1'b1;
        flag_we = 1'b1;
      end
      OP_AND: begin
        result  = a & operand;
        a_we    = 1'b1;
        flag_we = 1'b1;
      end
      OP_OR: begin
        result  = a | operand;
        a_we    = 1'b1;
        flag_we = 1'b1;
      end
      OP_XOR: begin
        result  = a ^ operand;
        a_we    = 1'b1;
        flag_we = 1'b1;
      end
      OP_SHL: begin
        result  = a << shamt;
        a_we    = 1'b1;
        flag_we = 1'b1;
      end
      OP_SHR: begin
        result  = a >> shamt;
        a_we    = 1'b1;
        flag_we = 1'b1;
      end
      default: begin
        result = a;
      end
    endcase
  end

endmodule

// File: rtl/accum_proc_gen2.sv
// rtl/accum_proc_gen2.sv - accumulator processor with register bank and handshaked I/O
module accum_proc_gen2
  import accum_proc_gen2_pkg::*;
#(
  parameter int DW   = 8,
  parameter int NREG = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW+3:0] instr,
  input  logic          instr_valid,
  output logic          instr_ready,
  output logic [DW-1:0] output_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] accumulator,
  output logic          signflag,
  output logic          overflowflag,
  output logic          zeroflag,
  output logic          illegal_op,
  output logic          busy
);

  localparam int RIW = $clog2(NREG);
  localparam int SHW = $clog2(DW);

  state_e          state_q, state_d;
  logic [DW+3:0]   instr_q;
  logic [DW-1:0]   regs [NREG];
  logic [3:0]      opcode;
  logic [DW-1:0]   imm;
  logic [RIW-1:0]  ridx;
  logic [DW-1:0]   operand;
  logic [DW-1:0]   alu_result;
  logic            alu_carry, alu_borrow, alu_a_we, alu_flag_we;
  logic            exec;

  assign opcode = instr_opcode(64'(instr_q), DW);
  assign imm    = DW'(instr_imm(64'(instr_q), DW));
  assign ridx   = RIW'(instr_ridx(64'(instr_q), DW, RIW));
  assign exec   = (state_q == ST_EXEC);

  // Immediate-form ops take I; everything else reads the register bank.
  always_comb begin
    operand = regs[ridx];
    if (opcode == OP_LDI || opcode == OP_ADDI || opcode == OP_SUBI) begin
      operand = imm;
    end
  end

  accum_proc_alu #(
    .DW  (DW),
    .SHW (SHW)
  ) u_alu (
    .opcode  (opcode),
    .a       (accumulator),
    .operand (operand),
    .shamt   (imm[SHW-1:0]),
    .result  (alu_result),
    .carry   (alu_carry),
    .borrow  (alu_borrow),
    .a_we    (alu_a_we),
    .flag_we (alu_flag_we)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs; instr_ready is masked while reset is held.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    busy        = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        instr_ready = reset_n;
        if (instr_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = (opcode == OP_OUT) ? ST_OUT_WAIT : ST_IDLE;
      end
      ST_OUT_WAIT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath: capture on accept, commit A/regs/flags at the end of EXEC, drive the output port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q       <= '0;
      accumulator   <= '0;
      signflag      <= 1'b0;
      overflowflag  <= 1'b0;
      zeroflag      <= 1'b0;
      illegal_op    <= 1'b0;
      output_result <= '0;
      out_valid     <= 1'b0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (state_q == ST_IDLE && instr_valid) begin
        instr_q <= instr;
      end
      if (exec) begin
        if (alu_a_we) begin
          accumulator <= alu_result;
          zeroflag    <= (alu_result == '0);
        end
        if (alu_flag_we) begin
          signflag     <= alu_borrow;
          overflowflag <= alu_carry;
        end
        if (opcode == OP_STR) begin
          regs[ridx] <= accumulator;
        end
        if (opcode == OP_ILL14 || opcode == OP_ILL15) begin
          illegal_op <= 1'b1;
        end
        if (opcode == OP_OUT) begin
          output_result <= accumulator;
          out_valid     <= 1'b1;
        end
      end
      if (state_q == ST_OUT_WAIT && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
